// File: rtl/router_pkg.sv
// Shared types and helpers for the Router trunk/branch datapath.
// Used by router_trunk_arbiter, Router and TESTBED.
package router_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } arb_state_t;

  localparam logic SRC_BR1 = 1'b0;
  localparam logic SRC_BR2 = 1'b1;

  // Branch word width: ceil(K*OUT_CH / floor(BOTTLENECK*OU/DELTA_X)) * BIT_OFM.
  function automatic int wire_num_calc(input int k, input int out_ch, input int bottleneck,
                                       input int ou, input int delta_x, input int bit_ofm);
    int per_cycle;
    per_cycle = (bottleneck * ou) / delta_x;
    if (per_cycle < 1) per_cycle = 1;
    return ((k * out_ch + per_cycle - 1) / per_cycle) * bit_ofm;
  endfunction

endpackage

// File: rtl/router_trunk_arbiter_if.sv
// Branch-side handshakes and trunk-side beat signals of the trunk arbiter.
// master = arbiter side, slave = branch sources / Router side.
interface router_trunk_arbiter_if #(parameter int WIRE_NUM = 29);

  logic                  br1_valid;
  logic [WIRE_NUM-1:0]   br1_data;
  logic                  br1_ready;
  logic                  br2_valid;
  logic [WIRE_NUM-1:0]   br2_data;
  logic                  br2_ready;
  logic [2*WIRE_NUM-1:0] trunk_data;
  logic                  trunk_write;
  logic [1:0]            trunk_mask;
  logic [1:0]            trunk_src;
  logic                  trunk_full;

  modport master (
    input  br1_valid, br1_data, br2_valid, br2_data, trunk_full,
    output br1_ready, br2_ready, trunk_data, trunk_write, trunk_mask, trunk_src
  );

  modport slave (
    output br1_valid, br1_data, br2_valid, br2_data, trunk_full,
    input  br1_ready, br2_ready, trunk_data, trunk_write, trunk_mask, trunk_src
  );

endinterface

// File: rtl/router_trunk_arbiter_rr.sv
// rr_arb2: two-requester round-robin grant; the pointer flips to the other
// requester whenever the granted request is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_id
);

  logic rr;

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    if (req == 2'b11) grant_id = rr;
    else if (req == 2'b10) grant_id = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr <= 1'b0;
    else if (accept) rr <= ~grant_id;
  end

endmodule

// File: rtl/router_trunk_arbiter.sv
// Packs branch words from two sources into 2-word trunk beats for the Router.
// Optional build macro ROUTER_ARB_STATS_EN adds acceptance/flush counters.
module router_trunk_arbiter
  import router_pkg::*;
#(
  parameter int BIT_OFM        = 29,
  parameter int HOW_MANY_PIXEL = 1,
  parameter int FLUSH_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst_n,
  router_trunk_arbiter_if.master bus
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [15:0] stat_br1_cnt,
  output logic [15:0] stat_br2_cnt,
  output logic [15:0] stat_flush_cnt
`endif
);

  localparam int WIRE_NUM = BIT_OFM * HOW_MANY_PIXEL;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  arb_state_t          state;
  logic [WIRE_NUM-1:0] lo_q;
  logic [WIRE_NUM-1:0] hi_q;
  logic [1:0]          mask_q;
  logic [1:0]          src_q;
  logic [CNT_W-1:0]    flush_cnt;

  logic                grant_valid;
  logic                grant_id;
  logic                can_take;
  logic                accept;
  logic                write_en;
  logic                flush_now;
  logic [WIRE_NUM-1:0] in_data;

  rr_arb2 u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         ({bus.br2_valid, bus.br1_valid}),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // A held beat blocks new words only while the downstream FIFO is full.
  assign can_take  = (state != FULL) || !bus.trunk_full;
  assign accept    = rst_n && grant_valid && can_take;
  assign write_en  = rst_n && (state == FULL) && !bus.trunk_full;
  assign flush_now = (state == HALF) && !accept && (flush_cnt == FLUSH_LAST);
  assign in_data   = (grant_id == SRC_BR2) ? bus.br2_data : bus.br1_data;

  assign bus.br1_ready   = accept && (grant_id == SRC_BR1);
  assign bus.br2_ready   = accept && (grant_id == SRC_BR2);
  assign bus.trunk_write = write_en;
  assign bus.trunk_data  = {hi_q, lo_q};
  assign bus.trunk_mask  = mask_q;
  assign bus.trunk_src   = src_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      lo_q      <= '0;
      hi_q      <= '0;
      mask_q    <= 2'b00;
      src_q     <= 2'b00;
      flush_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            lo_q      <= in_data;
            hi_q      <= '0;
            src_q     <= {1'b0, grant_id};
            mask_q    <= 2'b01;
            flush_cnt <= '0;
            state     <= HALF;
          end
        end
        HALF: begin
          if (accept) begin
            hi_q     <= in_data;
            src_q[1] <= grant_id;
            mask_q   <= 2'b11;
            state    <= FULL;
          end else if (flush_now) begin
            hi_q     <= '0;
            src_q[1] <= 1'b0;
            mask_q   <= 2'b01;
            state    <= FULL;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        FULL: begin
          // Sending and refilling in the same cycle keeps one beat per two words.
          if (write_en) begin
            if (accept) begin
              lo_q      <= in_data;
              hi_q      <= '0;
              src_q     <= {1'b0, grant_id};
              mask_q    <= 2'b01;
              flush_cnt <= '0;
              state     <= HALF;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br1_cnt   <= '0;
      stat_br2_cnt   <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (bus.br1_ready && stat_br1_cnt != 16'hFFFF) stat_br1_cnt <= stat_br1_cnt + 16'd1;
      if (bus.br2_ready && stat_br2_cnt != 16'hFFFF) stat_br2_cnt <= stat_br2_cnt + 16'd1;
      if (flush_now && stat_flush_cnt != 16'hFFFF) stat_flush_cnt <= stat_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_trunk_arbiter.sv
// Self-checking bench for router_trunk_arbiter: queue-based beat model plus
// directed scenarios with hand-computed expectations.
module tb_router_trunk_arbiter;

  localparam int W = 29;
  localparam int F = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  router_trunk_arbiter_if #(.WIRE_NUM(W)) bus ();

`ifdef ROUTER_ARB_STATS_EN
  logic [15:0] stat_br1_cnt, stat_br2_cnt, stat_flush_cnt;
`endif

  router_trunk_arbiter #(
    .BIT_OFM        (29),
    .HOW_MANY_PIXEL (1),
    .FLUSH_CYCLES   (F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .stat_br1_cnt   (stat_br1_cnt),
    .stat_br2_cnt   (stat_br2_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v1, input logic [W-1:0] d1,
                               input logic v2, input logic [W-1:0] d2, input logic full);
    @(posedge clk);
    #1;
    bus.br1_valid  = v1;
    bus.br1_data   = d1;
    bus.br2_valid  = v2;
    bus.br2_data   = d2;
    bus.trunk_full = full;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.br1_valid  = 1'b0;
    bus.br2_valid  = 1'b0;
    bus.trunk_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Model: words waiting to be paired, plus at most one completed beat.
  logic           m_rr = 1'b0;
  logic [W-1:0]   m_wq[$];
  logic           m_sq[$];
  int             m_idle = 0;
  logic           m_beat = 1'b0;
  logic [2*W-1:0] m_bdata = '0;
  logic [1:0]     m_bmask = 2'b00;
  logic [1:0]     m_bsrc = 2'b00;
  logic           m_clear = 1'b0;

  always @(negedge clk) begin
    logic gv, gid, take, ex_w;
    logic [W-1:0] wd;
    if (!rst_n) begin
      checkOutput("rst_ready", {62'd0, bus.br2_ready, bus.br1_ready}, 64'd0);
      checkOutput("rst_write", {63'd0, bus.trunk_write}, 64'd0);
      if (m_clear) begin
        checkOutput("rst_data", {6'd0, bus.trunk_data}, 64'd0);
        checkOutput("rst_mask", {62'd0, bus.trunk_mask}, 64'd0);
      end
      m_rr = 1'b0;
      m_wq.delete();
      m_sq.delete();
      m_idle = 0;
      m_beat = 1'b0;
      m_clear = 1'b1;
    end else begin
      gv   = bus.br1_valid || bus.br2_valid;
      gid  = (bus.br1_valid && bus.br2_valid) ? m_rr : !bus.br1_valid;
      take = gv && (!m_beat || !bus.trunk_full);
      ex_w = m_beat && !bus.trunk_full;
      checkOutput("br1_ready", {63'd0, bus.br1_ready}, {63'd0, take && !gid});
      checkOutput("br2_ready", {63'd0, bus.br2_ready}, {63'd0, take && gid});
      checkOutput("trunk_write", {63'd0, bus.trunk_write}, {63'd0, ex_w});
      if (ex_w) begin
        checkOutput("beat_data", {6'd0, bus.trunk_data}, {6'd0, m_bdata});
        checkOutput("beat_mask", {62'd0, bus.trunk_mask}, {62'd0, m_bmask});
        checkOutput("beat_src", {62'd0, bus.trunk_src}, {62'd0, m_bsrc});
      end else if (m_clear) begin
        checkOutput("idle_data", {6'd0, bus.trunk_data}, 64'd0);
        checkOutput("idle_mask_src", {60'd0, bus.trunk_mask, bus.trunk_src}, 64'd0);
      end
      if (ex_w) m_beat = 1'b0;
      if (take) begin
        wd = gid ? bus.br2_data : bus.br1_data;
        m_wq.push_back(wd);
        m_sq.push_back(gid);
        m_rr = ~gid;
        m_idle = 0;
        m_clear = 1'b0;
        if (m_wq.size() == 2) begin
          m_bdata = {m_wq[1], m_wq[0]};
          m_bmask = 2'b11;
          m_bsrc  = {m_sq[1], m_sq[0]};
          m_beat  = 1'b1;
          m_wq.delete();
          m_sq.delete();
        end
      end else if (m_wq.size() == 1) begin
        m_idle++;
        if (m_idle == F) begin
          m_bdata = {{W{1'b0}}, m_wq[0]};
          m_bmask = 2'b01;
          m_bsrc  = {1'b0, m_sq[0]};
          m_beat  = 1'b1;
          m_wq.delete();
          m_sq.delete();
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] wa, wb, wc, we, wd;
    int nw, found;
    bus.br1_valid  = 1'b0;
    bus.br1_data   = '0;
    bus.br2_valid  = 1'b0;
    bus.br2_data   = '0;
    bus.trunk_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_state", {4'd0, bus.trunk_write, bus.trunk_mask, bus.trunk_src, bus.trunk_data},
                64'd0);

    // Scenario 1: two br1 words pair into one beat.
    wa = 29'h0AAA_AAAA;
    wb = 29'h1555_5555;
    applyStimulus(1'b1, wa, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, wb, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t1_write", {63'd0, bus.trunk_write}, 64'd1);
    checkOutput("t1_data", {6'd0, bus.trunk_data}, {6'd0, 29'h1555_5555, 29'h0AAA_AAAA});
    checkOutput("t1_mask_src", {60'd0, bus.trunk_mask, bus.trunk_src}, 64'h0C);

    // Scenario 2: both sources streaming alternate, one beat per two cycles.
    doReset();
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, W'(32'h100 + i), 1'b1, W'(32'h200 + i), 1'b0);
      @(negedge clk);
      if (bus.trunk_write) begin
        nw++;
        checkOutput("t2_src", {62'd0, bus.trunk_src}, 64'd2);
      end
    end
    checkOutput("t2_beats", 64'(nw), 64'd4);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);

    // Scenario 3: lone word is flushed on the 9th cycle after acceptance.
    wc = 29'h0123_4567;
    applyStimulus(1'b1, wc, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.trunk_write) begin
        found = k;
        break;
      end
    end
    checkOutput("t3_flush_cycle", 64'(found), 64'd9);
    checkOutput("t3_data", {6'd0, bus.trunk_data}, {6'd0, 29'd0, 29'h0123_4567});
    checkOutput("t3_mask_src", {60'd0, bus.trunk_mask, bus.trunk_src}, 64'h04);

    // Scenario 4: backpressure holds the beat; release sends and refills.
    wa = 29'h0000_0011;
    wb = 29'h0000_0022;
    we = 29'h1EEE_EEEE;
    applyStimulus(1'b1, wa, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, wb, 1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, '0, 1'b1, we, 1'b1);
      @(negedge clk);
      checkOutput("t4_hold_write", {63'd0, bus.trunk_write}, 64'd0);
      checkOutput("t4_hold_ready", {63'd0, bus.br2_ready}, 64'd0);
      checkOutput("t4_hold_data", {6'd0, bus.trunk_data}, {6'd0, 29'h22, 29'h11});
    end
    applyStimulus(1'b0, '0, 1'b1, we, 1'b0);
    @(negedge clk);
    checkOutput("t4_release_write", {63'd0, bus.trunk_write}, 64'd1);
    checkOutput("t4_release_ready", {63'd0, bus.br2_ready}, 64'd1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t4_lo", {35'd0, bus.trunk_data[W-1:0]}, {35'd0, 29'h1EEE_EEEE});
    checkOutput("t4_mask_src", {60'd0, bus.trunk_mask, bus.trunk_src}, 64'h05);
    repeat (12) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);

    // Scenario 5: reset discards a half-filled beat.
    wd = 29'h0DDD_DDDD;
    applyStimulus(1'b1, wd, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    doReset();
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.trunk_write) nw++;
    end
    checkOutput("t5_no_write", 64'(nw), 64'd0);
    checkOutput("t5_outputs", {4'd0, bus.trunk_write, bus.trunk_mask, bus.trunk_src, bus.trunk_data},
                64'd0);

`ifdef ROUTER_ARB_STATS_EN
    // Scenario 6: acceptance counter saturates.
    doReset();
    for (int i = 0; i < 70010; i++) applyStimulus(1'b1, W'(i), 1'b0, '0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t6_br1_cnt", {48'd0, stat_br1_cnt}, 64'hFFFF);
    checkOutput("t6_br2_cnt", {48'd0, stat_br2_cnt}, 64'd0);
    checkOutput("t6_flush_cnt", {48'd0, stat_flush_cnt}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
